// File: rtl/button_debounce_pkg.sv
// Shared state encodings and default qualify window for the switch debouncer and its
// downstream pulse stage.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_L2H  = 2'b01,
        S_HIGH = 2'b11,
        S_H2L  = 2'b10
    } db_state_e;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; both flops clear on reset.
// Latency 2 clk edges; no backpressure (free-running).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw pad switch into a clean level with rise/fall strobes and a saturating press count.
// Latency DEBOUNCE_CYCLES+1 edges from capture to db_level; no backpressure (free-running).
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PRESS_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_in,
    input  logic                   cnt_clr,
    output logic                   db_level,
    output logic                   db_rise,
    output logic                   db_fall,
    output logic                   bouncing,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                   s2;
    db_state_e              state_q,    state_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic                   level_q,    level_d;
    logic                   rise_q,     rise_d;
    logic                   fall_q,     fall_d;
    logic                   bouncing_q, bouncing_d;
    logic [PRESS_CNT_W-1:0] press_q,    press_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_in),
        .q_o   (s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOW;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            bouncing_q <= 1'b0;
            press_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            bouncing_q <= bouncing_d;
            press_q    <= press_d;
        end
    end

    // cnt counts consecutive samples opposing the stable level; any agreeing sample aborts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        bouncing_d = bouncing_q;
        case (state_q)
            S_LOW: begin
                if (s2) begin
                    state_d    = S_L2H;
                    cnt_d      = CNT_W'(1);
                    bouncing_d = 1'b1;
                end
            end
            S_L2H: begin
                if (!s2) begin
                    state_d    = S_LOW;
                    cnt_d      = '0;
                    bouncing_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_HIGH;
                    cnt_d      = '0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                    bouncing_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s2) begin
                    state_d    = S_H2L;
                    cnt_d      = CNT_W'(1);
                    bouncing_d = 1'b1;
                end
            end
            S_H2L: begin
                if (s2) begin
                    state_d    = S_HIGH;
                    cnt_d      = '0;
                    bouncing_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_LOW;
                    cnt_d      = '0;
                    level_d    = 1'b0;
                    fall_d     = 1'b1;
                    bouncing_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = S_LOW;
                cnt_d      = '0;
                level_d    = 1'b0;
                bouncing_d = 1'b0;
            end
        endcase
    end

    // A clear coinciding with an accepted press still records that press.
    always_comb begin
        press_d = press_q;
        if (cnt_clr) begin
            press_d = rise_d ? PRESS_CNT_W'(1) : '0;
        end else if (rise_d && !(&press_q)) begin
            press_d = press_q + PRESS_CNT_W'(1);
        end
    end

    assign db_level  = level_q;
    assign db_rise   = rise_q;
    assign db_fall   = fall_q;
    assign bouncing  = bouncing_q;
    assign press_cnt = press_q;

endmodule
